maze_agent_driver: RTL and testbench

Transition generator that drives the Q-learning accelerator from the agent side. It walks an 8x8 grid maze with an epsilon-greedy policy and computes each move and its reward. Each transition (state, action, next state, reward) is presented to the accelerator's update port for a fixed hold window. The Q row returned for the new state is captured and used for the next greedy decision. It sits between the host's start/done control and the accelerator.

---
 rtl/qlearn_pkg.sv | 38 +++
 rtl/maze_lfsr.sv | 27 ++
 rtl/maze_agent_driver.sv | 203 ++++++++++++++++++++
 tb/tb_maze_agent_driver.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/qlearn_pkg.sv
// Shared types and constants for the Q-learning agent side: action codes,
// field widths, FSM state encoding and the greedy-choice helper.
package qlearn_pkg;

  localparam int STATE_W = 6;
  localparam int ACT_W   = 4;
  localparam int Q_W     = 16;

  localparam logic [ACT_W-1:0] ACT_UP    = 4'd0;
  localparam logic [ACT_W-1:0] ACT_DOWN  = 4'd1;
  localparam logic [ACT_W-1:0] ACT_LEFT  = 4'd2;
  localparam logic [ACT_W-1:0] ACT_RIGHT = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_MOVE,
    ST_ISSUE,
    ST_EPEND,
    ST_FINISH
  } fsm_state_t;

  // Signed maximum over the four Q lanes; strict '>' keeps the lowest index on ties.
  function automatic logic [1:0] greedy_action(input logic [4*Q_W-1:0] row);
    logic signed [Q_W-1:0] best;
    logic [1:0]            idx;
    best = row[Q_W-1:0];
    idx  = 2'd0;
    for (int a = 1; a < 4; a++) begin
      if ($signed(row[Q_W*a +: Q_W]) > best) begin
        best = row[Q_W*a +: Q_W];
        idx  = 2'(a);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/maze_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps only when enabled;
// the low RND_W bits feed the exploration decision.
module maze_lfsr #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          RND_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [RND_W-1:0] rnd
);

  logic [15:0] lfsr_reg;
  logic        feedback;

  assign feedback = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign rnd      = lfsr_reg[RND_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= SEED;
    end else if (en) begin
      lfsr_reg <= {lfsr_reg[14:0], feedback};
    end
  end

endmodule

// File: rtl/maze_agent_driver.sv
// Epsilon-greedy maze walker that generates (state, action, next, reward)
// transitions for the Q-learning accelerator and captures the returned Q row.
module maze_agent_driver
  import qlearn_pkg::*;
#(
  parameter logic [STATE_W-1:0]  START_STATE   = 6'd0,
  parameter logic [STATE_W-1:0]  GOAL_STATE    = 6'd63,
  parameter logic [63:0]         WALL_MAP      = 64'h0,
  parameter logic signed [Q_W-1:0] GOAL_REWARD  = 16'sd100,
  parameter logic signed [Q_W-1:0] WALL_PENALTY = 16'sd10,
  parameter logic signed [Q_W-1:0] STEP_REWARD  = -16'sd1,
  parameter logic [7:0]          EPSILON       = 8'd26,
  parameter logic [15:0]         MAX_STEPS     = 16'd256,
  parameter logic [15:0]         NUM_EPISODES  = 16'd100,
  parameter int                  UPDATE_CYCLES = 3,
  parameter logic [15:0]         LFSR_SEED     = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 acc_en,
  output logic [ACT_W-1:0]     acc_action,
  output logic [STATE_W-1:0]   acc_state,
  output logic [STATE_W-1:0]   acc_next_state,
  output logic [Q_W-1:0]       acc_reward,
  input  logic [4*Q_W-1:0]     q_row_in,
  output logic [15:0]          episode_count,
  output logic [15:0]          step_count
);

  localparam int CNT_W = $clog2(UPDATE_CYCLES + 1);

  fsm_state_t          state_reg, state_next;
  logic [STATE_W-1:0]  cur_reg;
  logic [STATE_W-1:0]  acc_state_reg, acc_next_state_reg;
  logic [ACT_W-1:0]    acc_action_reg;
  logic [Q_W-1:0]      acc_reward_reg;
  logic [4*Q_W-1:0]    q_row_reg;
  logic [1:0]          action_reg;
  logic [15:0]         step_count_reg, episode_count_reg;
  logic [CNT_W-1:0]    issue_cnt_reg;
  logic [9:0]          rnd;

  logic                lfsr_en;
  logic                last_issue;
  logic [15:0]         step_inc;
  logic                ep_end, ep_last;
  logic                explore;
  logic [2:0]          cur_row, cur_col, tgt_row, tgt_col;
  logic                off_grid, bump;
  logic [STATE_W-1:0]  target;
  logic [Q_W-1:0]      move_reward;

  maze_lfsr #(
    .SEED  (LFSR_SEED),
    .RND_W (10)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lfsr_en),
    .rnd   (rnd)
  );

  assign acc_action     = acc_action_reg;
  assign acc_state      = acc_state_reg;
  assign acc_next_state = acc_next_state_reg;
  assign acc_reward     = acc_reward_reg;
  assign episode_count  = episode_count_reg;
  assign step_count     = step_count_reg;

  assign lfsr_en    = (state_reg != ST_IDLE);
  assign last_issue = (issue_cnt_reg == CNT_W'(UPDATE_CYCLES - 1));
  assign step_inc   = step_count_reg + 16'd1;
  // Goal and step cap share one episode end; the goal reward was already issued.
  assign ep_end     = (acc_next_state_reg == GOAL_STATE) || (step_inc == MAX_STEPS);
  assign ep_last    = ((episode_count_reg + 16'd1) == NUM_EPISODES);
  assign explore    = (rnd[7:0] < EPSILON);

  // Grid move: row is the upper field, so up decrements the row.
  always_comb begin
    cur_row  = cur_reg[5:3];
    cur_col  = cur_reg[2:0];
    tgt_row  = cur_row;
    tgt_col  = cur_col;
    off_grid = 1'b0;
    case ({2'b00, action_reg})
      ACT_UP: begin
        off_grid = (cur_row == 3'd0);
        tgt_row  = cur_row - 3'd1;
      end
      ACT_DOWN: begin
        off_grid = (cur_row == 3'd7);
        tgt_row  = cur_row + 3'd1;
      end
      ACT_LEFT: begin
        off_grid = (cur_col == 3'd0);
        tgt_col  = cur_col - 3'd1;
      end
      ACT_RIGHT: begin
        off_grid = (cur_col == 3'd7);
        tgt_col  = cur_col + 3'd1;
      end
      default: off_grid = 1'b1;
    endcase
    target = {tgt_row, tgt_col};
    bump   = off_grid || WALL_MAP[target];
    if (bump) begin
      move_reward = -WALL_PENALTY;
    end else if (target == GOAL_STATE) begin
      move_reward = GOAL_REWARD;
    end else begin
      move_reward = STEP_REWARD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != ST_IDLE);
    done       = (state_reg == ST_FINISH);
    acc_en     = (state_reg == ST_ISSUE);
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (NUM_EPISODES == 16'd0) ? ST_FINISH : ST_SELECT;
        end
      end
      ST_SELECT: state_next = ST_MOVE;
      ST_MOVE:   state_next = ST_ISSUE;
      ST_ISSUE: begin
        if (last_issue) begin
          state_next = ep_end ? ST_EPEND : ST_SELECT;
        end
      end
      ST_EPEND:  state_next = ep_last ? ST_FINISH : ST_SELECT;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_reg            <= START_STATE;
      acc_state_reg      <= '0;
      acc_next_state_reg <= '0;
      acc_action_reg     <= '0;
      acc_reward_reg     <= '0;
      q_row_reg          <= '0;
      action_reg         <= '0;
      step_count_reg     <= '0;
      episode_count_reg  <= '0;
      issue_cnt_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            episode_count_reg <= '0;
            step_count_reg    <= '0;
            cur_reg           <= START_STATE;
            q_row_reg         <= '0;
          end
        end
        ST_SELECT: begin
          action_reg <= explore ? rnd[9:8] : greedy_action(q_row_reg);
        end
        ST_MOVE: begin
          acc_action_reg     <= {2'b00, action_reg};
          acc_state_reg      <= cur_reg;
          acc_next_state_reg <= bump ? cur_reg : target;
          acc_reward_reg     <= move_reward;
          issue_cnt_reg      <= '0;
        end
        ST_ISSUE: begin
          if (last_issue) begin
            q_row_reg      <= q_row_in;
            step_count_reg <= step_inc;
            cur_reg        <= acc_next_state_reg;
            issue_cnt_reg  <= '0;
          end else begin
            issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
          end
        end
        ST_EPEND: begin
          episode_count_reg <= episode_count_reg + 16'd1;
          cur_reg           <= START_STATE;
          q_row_reg         <= '0;
          step_count_reg    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_agent_driver.sv
// Directed bench: two 4-step-capped episodes on a small maze with a wall,
// a start in FINISH, and an asynchronous reset in the middle of ISSUE.
module tb_maze_agent_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, acc_en;
  logic [3:0]  acc_action;
  logic [5:0]  acc_state, acc_next_state;
  logic [15:0] acc_reward;
  logic [63:0] q_row_in = 64'h0;
  logic [15:0] episode_count, step_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  maze_agent_driver #(
    .START_STATE   (6'd0),
    .GOAL_STATE    (6'd2),
    .WALL_MAP      (64'h0000_0000_0000_0200),
    .EPSILON       (8'd0),
    .MAX_STEPS     (16'd4),
    .NUM_EPISODES  (16'd2),
    .UPDATE_CYCLES (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .acc_en         (acc_en),
    .acc_action     (acc_action),
    .acc_state      (acc_state),
    .acc_next_state (acc_next_state),
    .acc_reward     (acc_reward),
    .q_row_in       (q_row_in),
    .episode_count  (episode_count),
    .step_count     (step_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Waits for the next ISSUE window, checks every cycle of it, then returns
  // at the first negedge with acc_en low.
  task automatic run_step(input int idx, input int exp_wait, input logic [3:0] e_act,
                          input logic [5:0] e_st, input logic [5:0] e_nx,
                          input logic [15:0] e_rew, input logic [15:0] e_sc,
                          input logic [15:0] e_ec, input logic [63:0] q_ret,
                          input bit poke_start);
    int n;
    int len;
    n = 0;
    len = 0;
    do begin
      @(negedge clk);
      n++;
      start = (poke_start && n == 1);
    end while (!acc_en && n < 40);
    start = 1'b0;
    check($sformatf("s%0d_wait", idx), 64'(n), 64'(exp_wait));
    check($sformatf("s%0d_sc", idx), 64'(step_count), 64'(e_sc));
    check($sformatf("s%0d_ec", idx), 64'(episode_count), 64'(e_ec));
    q_row_in = q_ret;
    while (acc_en && len < 40) begin
      len++;
      check($sformatf("s%0d_act", idx), 64'(acc_action), 64'(e_act));
      check($sformatf("s%0d_st", idx), 64'(acc_state), 64'(e_st));
      check($sformatf("s%0d_nx", idx), 64'(acc_next_state), 64'(e_nx));
      check($sformatf("s%0d_rew", idx), 64'(acc_reward), 64'(e_rew));
      @(negedge clk);
    end
    check($sformatf("s%0d_len", idx), 64'(len), 64'd3);
    $display("step %0d: act=%0d st=%0d nx=%0d rew=%0d wait=%0d len=%0d",
             idx, acc_action, acc_state, acc_next_state, $signed(acc_reward), n, len);
  endtask

  initial begin
    int n;
    int en_seen;
    int busy_seen;

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_en", 64'(acc_en), 64'd0);
    check("rst_rew", 64'(acc_reward), 64'd0);
    check("rst_ec", 64'(episode_count), 64'd0);
    check("rst_sc", 64'(step_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;

    // Episode 1: edge bump, tie-break, signed greedy, wall bump, step cap.
    run_step(1, 3, 4'd0, 6'd0, 6'd0, 16'hFFF6, 16'd0, 16'd0, 64'h0005_FFF0_0003_0005, 1'b0);
    run_step(2, 2, 4'd0, 6'd0, 6'd0, 16'hFFF6, 16'd1, 16'd0, 64'h0009_0002_0002_0002, 1'b0);
    run_step(3, 2, 4'd3, 6'd0, 6'd1, 16'hFFFF, 16'd2, 16'd0, 64'hFFFF_FFFE_0004_0001, 1'b1);
    run_step(4, 2, 4'd1, 6'd1, 6'd1, 16'hFFF6, 16'd3, 16'd0, 64'h0007_0000_0000_0000, 1'b0);
    check("ep1_sc", 64'(step_count), 64'd4);
    check("ep1_ec", 64'(episode_count), 64'd0);
    check("ep1_done", 64'(done), 64'd0);
    check("ep1_busy", 64'(busy), 64'd1);

    // Episode 2: cleared Q row, left edge bump, then goal on the capped step.
    run_step(5, 3, 4'd0, 6'd0, 6'd0, 16'hFFF6, 16'd0, 16'd1, 64'h0000_0008_0000_0000, 1'b0);
    run_step(6, 2, 4'd2, 6'd0, 6'd0, 16'hFFF6, 16'd1, 16'd1, 64'h0006_0000_0000_0000, 1'b0);
    run_step(7, 2, 4'd3, 6'd0, 6'd1, 16'hFFFF, 16'd2, 16'd1, 64'h0006_0000_0000_0000, 1'b0);
    run_step(8, 2, 4'd3, 6'd1, 6'd2, 16'h0064, 16'd3, 16'd1, 64'h0, 1'b0);
    check("ep2_done_early", 64'(done), 64'd0);
    check("ep2_sc", 64'(step_count), 64'd4);
    @(negedge clk);
    check("fin_done", 64'(done), 64'd1);
    check("fin_busy", 64'(busy), 64'd1);
    check("fin_ec", 64'(episode_count), 64'd2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("idle_done", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_en", 64'(acc_en), 64'd0);
    check("idle_nx_hold", 64'(acc_next_state), 64'd2);
    check("idle_rew_hold", 64'(acc_reward), 64'h0064);
    @(negedge clk);
    check("fin_start_ignored", 64'(busy), 64'd0);
    $display("run 1 complete: episodes=%0d", episode_count);

    // New run, then asynchronous reset in the second ISSUE cycle.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("run2_busy", 64'(busy), 64'd1);
    check("run2_ec", 64'(episode_count), 64'd0);
    n = 0;
    while (!acc_en && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("run2_wait", 64'(n), 64'd2);
    check("run2_rew", 64'(acc_reward), 64'hFFF6);
    @(negedge clk);
    check("run2_en2", 64'(acc_en), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_en", 64'(acc_en), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_rew", 64'(acc_reward), 64'd0);
    check("arst_act", 64'(acc_action), 64'd0);
    check("arst_sc", 64'(step_count), 64'd0);
    $display("reset asserted mid-ISSUE: acc_en=%0d busy=%0d", acc_en, busy);
    @(negedge clk);
    rst_n = 1'b1;
    en_seen = 0;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (acc_en) en_seen++;
      if (busy) busy_seen++;
    end
    check("post_rst_en", 64'(en_seen), 64'd0);
    check("post_rst_busy", 64'(busy_seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
